// File: rtl/pc_sequencer.sv
// Control-flow sequencer: converts decoded jump/call/return/branch/interrupt
// requests into per-cycle PC load/offset commands, with a return-address stack.
module pc_sequencer #(
  parameter int unsigned RAS_DEPTH  = 8,
  parameter logic [15:0] IRQ_VECTOR = 16'h0010
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] CounterValue,
  input  logic        Stall,
  input  logic        BranchReq,
  input  logic [2:0]  BranchCond,
  input  logic [8:0]  BranchOffset,
  input  logic        JumpReq,
  input  logic [15:0] JumpTarget,
  input  logic        CallReq,
  input  logic        RetReq,
  input  logic        RetiReq,
  input  logic        Zero,
  input  logic        Negative,
  input  logic        Carry,
  input  logic        IrqReq,
  output logic [15:0] LoadValue,
  output logic        LoadEnable,
  output logic [8:0]  Offset,
  output logic        OffsetEnable,
  output logic        Flush,
  output logic        IrqAck,
  output logic        InIrq,
  output logic        StackOverflow,
  output logic        StackUnderflow
);

  localparam int unsigned SPW = $clog2(RAS_DEPTH + 1);
  localparam int unsigned IW  = $clog2(RAS_DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t         state, state_next;
  logic [15:0]    stack [RAS_DEPTH];
  logic [SPW-1:0] sp, top_idx;
  logic           full, empty, cond_ok, taken;
  logic           push, pop, set_inirq, clr_inirq, set_ovf, set_unf;
  logic [15:0]    push_data;
  logic           in_irq, ovf, unf;

  assign full    = (sp == SPW'(RAS_DEPTH));
  assign empty   = (sp == '0);
  assign top_idx = sp - SPW'(1);

  assign InIrq          = in_irq;
  assign StackOverflow  = ovf;
  assign StackUnderflow = unf;

  always_comb begin
    unique case (BranchCond)
      3'd0:    cond_ok = 1'b1;
      3'd1:    cond_ok = Zero;
      3'd2:    cond_ok = !Zero;
      3'd3:    cond_ok = Negative;
      3'd4:    cond_ok = !Negative;
      3'd5:    cond_ok = Carry;
      3'd6:    cond_ok = !Carry;
      default: cond_ok = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = taken ? FLUSH : RUN;
  end

  // Commands and stack/flag side effects share one priority chain so a
  // blocked call/return never falls through to a lower-priority request.
  always_comb begin
    LoadValue    = '0;
    LoadEnable   = 1'b0;
    Offset       = '0;
    OffsetEnable = 1'b0;
    Flush        = 1'b0;
    IrqAck       = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    push_data    = '0;
    taken        = 1'b0;
    set_inirq    = 1'b0;
    clr_inirq    = 1'b0;
    set_ovf      = 1'b0;
    set_unf      = 1'b0;
    if (!Reset) begin
      if (state == FLUSH) begin
        Flush        = 1'b1;
        OffsetEnable = 1'b1;
      end else if (Stall) begin
        OffsetEnable = 1'b1;
      end else if (JumpReq) begin
        LoadValue  = JumpTarget;
        LoadEnable = 1'b1;
        taken      = 1'b1;
      end else if (CallReq) begin
        if (!full) begin
          push       = 1'b1;
          push_data  = CounterValue + 16'd1;
          LoadValue  = JumpTarget;
          LoadEnable = 1'b1;
          taken      = 1'b1;
        end else begin
          set_ovf = 1'b1;
        end
      end else if (RetReq || RetiReq) begin
        if (!empty) begin
          pop        = 1'b1;
          LoadValue  = stack[top_idx[IW-1:0]];
          LoadEnable = 1'b1;
          taken      = 1'b1;
          clr_inirq  = !RetReq;
        end else begin
          set_unf = 1'b1;
        end
      end else if (BranchReq) begin
        if (cond_ok) begin
          OffsetEnable = 1'b1;
          Offset       = BranchOffset;
          taken        = 1'b1;
        end
      end else if (IrqReq && !in_irq && !full) begin
        push       = 1'b1;
        push_data  = CounterValue;
        LoadValue  = IRQ_VECTOR;
        LoadEnable = 1'b1;
        IrqAck     = 1'b1;
        set_inirq  = 1'b1;
        taken      = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sp     <= '0;
      in_irq <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (push)     sp <= sp + SPW'(1);
      else if (pop) sp <= sp - SPW'(1);
      if (set_inirq)      in_irq <= 1'b1;
      else if (clr_inirq) in_irq <= 1'b0;
      if (set_ovf) ovf <= 1'b1;
      if (set_unf) unf <= 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (push) stack[sp[IW-1:0]] <= push_data;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: closes the PC loop, runs directed vector table and
// random traffic against a queue-based reference model.
module tb_pc_sequencer;

  localparam int unsigned D  = 8;
  localparam logic [15:0] IV = 16'h0010;

  logic        Clock = 1'b0;
  logic        Reset, Stall, BranchReq, JumpReq, CallReq, RetReq, RetiReq;
  logic        Zero, Negative, Carry, IrqReq;
  logic [15:0] CounterValue, JumpTarget, LoadValue;
  logic [2:0]  BranchCond;
  logic [8:0]  BranchOffset, Offset;
  logic        LoadEnable, OffsetEnable, Flush, IrqAck, InIrq;
  logic        StackOverflow, StackUnderflow;

  always #5 Clock = ~Clock;

  pc_sequencer #(.RAS_DEPTH(D), .IRQ_VECTOR(IV)) dut (
    .Clock(Clock), .Reset(Reset), .CounterValue(CounterValue), .Stall(Stall),
    .BranchReq(BranchReq), .BranchCond(BranchCond), .BranchOffset(BranchOffset),
    .JumpReq(JumpReq), .JumpTarget(JumpTarget), .CallReq(CallReq),
    .RetReq(RetReq), .RetiReq(RetiReq), .Zero(Zero), .Negative(Negative),
    .Carry(Carry), .IrqReq(IrqReq), .LoadValue(LoadValue), .LoadEnable(LoadEnable),
    .Offset(Offset), .OffsetEnable(OffsetEnable), .Flush(Flush), .IrqAck(IrqAck),
    .InIrq(InIrq), .StackOverflow(StackOverflow), .StackUnderflow(StackUnderflow)
  );

  typedef struct {
    bit rst, stall, br;
    bit [2:0] cond;
    bit [8:0] off;
    bit jmp;
    bit [15:0] tgt;
    bit call, ret, reti, z, n, c, irq;
    bit chk;
    bit [15:0] exp_pc;
    bit exp_flush;
    bit [3:0] exp_fl;   // {IrqAck this cycle, InIrq, overflow, underflow after edge}
  } vec_t;

  typedef struct {
    bit [15:0] lv;
    bit le;
    bit [8:0] off;
    bit oe, fl, ack;
  } cmd_t;

  typedef enum int {K_IDLE, K_RST, K_BR, K_JMP, K_CALL, K_RET, K_RETI, K_IRQ, K_JCS, K_JC} kind_t;

  int n_checks = 0;
  int n_fail   = 0;
  bit [15:0] pc;
  vec_t tbl[$];

  bit [15:0] m_stk[$];
  bit m_flush, m_inirq, m_ovf, m_unf;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: actual %h required %h", name, idx, act, exp);
    end
  endtask

  function automatic bit [15:0] next_pc(bit [15:0] cv, bit le, bit [15:0] lv, bit oe, bit [8:0] off);
    if (le) return lv;
    if (oe) return cv + {{7{off[8]}}, off};
    return cv + 16'd1;
  endfunction

  task automatic model_eval(input vec_t v, input bit [15:0] cv, output cmd_t e);
    bit [7:0] truth;
    e = '{default: 0};
    truth = {1'b0, !v.c, v.c, !v.n, v.n, !v.z, v.z, 1'b1};
    if (v.rst) begin
      m_stk.delete();
      m_flush = 0; m_inirq = 0; m_ovf = 0; m_unf = 0;
    end else if (m_flush) begin
      e.fl = 1; e.oe = 1; m_flush = 0;
    end else if (v.stall) begin
      e.oe = 1;
    end else if (v.jmp) begin
      e.le = 1; e.lv = v.tgt; m_flush = 1;
    end else if (v.call) begin
      if (m_stk.size() < D) begin
        m_stk.push_back(cv + 16'd1);
        e.le = 1; e.lv = v.tgt; m_flush = 1;
      end else m_ovf = 1;
    end else if (v.ret || v.reti) begin
      if (m_stk.size() > 0) begin
        e.le = 1; e.lv = m_stk.pop_back(); m_flush = 1;
        if (!v.ret) m_inirq = 0;
      end else m_unf = 1;
    end else if (v.br) begin
      if (truth[v.cond]) begin
        e.oe = 1; e.off = v.off; m_flush = 1;
      end
    end else if (v.irq && !m_inirq && m_stk.size() < D) begin
      m_stk.push_back(cv);
      e.le = 1; e.lv = IV; e.ack = 1; m_inirq = 1; m_flush = 1;
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    cmd_t e;
    bit [15:0] npc_dut, npc_model;
    Reset = v.rst; Stall = v.stall; BranchReq = v.br; BranchCond = v.cond;
    BranchOffset = v.off; JumpReq = v.jmp; JumpTarget = v.tgt; CallReq = v.call;
    RetReq = v.ret; RetiReq = v.reti; Zero = v.z; Negative = v.n; Carry = v.c;
    IrqReq = v.irq; CounterValue = pc;
    @(negedge Clock);
    model_eval(v, pc, e);
    check("cmd", idx, {3'b0, LoadValue, LoadEnable, Offset, OffsetEnable, Flush, IrqAck},
          {3'b0, e.lv, e.le, e.off, e.oe, e.fl, e.ack});
    npc_dut   = v.rst ? 16'h0 : next_pc(pc, LoadEnable, LoadValue, OffsetEnable, Offset);
    npc_model = v.rst ? 16'h0 : next_pc(pc, e.le, e.lv, e.oe, e.off);
    if (v.chk) begin
      check("tbl_flush", idx, {31'b0, Flush}, {31'b0, v.exp_flush});
      check("tbl_ack", idx, {31'b0, IrqAck}, {31'b0, v.exp_fl[3]});
    end
    @(posedge Clock);
    #1;
    pc = npc_dut;
    check("pc", idx, {16'b0, pc}, {16'b0, npc_model});
    check("regs", idx, {29'b0, InIrq, StackOverflow, StackUnderflow}, {29'b0, m_inirq, m_ovf, m_unf});
    if (v.chk) begin
      check("tbl_pc", idx, {16'b0, pc}, {16'b0, v.exp_pc});
      check("tbl_flags", idx, {29'b0, InIrq, StackOverflow, StackUnderflow}, {29'b0, v.exp_fl[2:0]});
    end
  endtask

  function automatic vec_t mk(kind_t k, bit [15:0] arg, bit [2:0] cond, bit z,
                              bit [15:0] epc, bit ef, bit [3:0] efl);
    vec_t v = '{default: 0};
    v.chk = 1; v.exp_pc = epc; v.exp_flush = ef; v.exp_fl = efl;
    case (k)
      K_RST:  v.rst = 1;
      K_BR:   begin v.br = 1; v.off = arg[8:0]; v.cond = cond; v.z = z; end
      K_JMP:  begin v.jmp = 1; v.tgt = arg; end
      K_CALL: begin v.call = 1; v.tgt = arg; end
      K_RET:  v.ret = 1;
      K_RETI: v.reti = 1;
      K_IRQ:  v.irq = 1;
      K_JCS:  begin v.jmp = 1; v.call = 1; v.stall = 1; v.tgt = arg; end
      K_JC:   begin v.jmp = 1; v.call = 1; v.tgt = arg; end
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    vec_t v;
    Reset = 1; Stall = 0; BranchReq = 0; BranchCond = 0; BranchOffset = 0;
    JumpReq = 0; JumpTarget = 0; CallReq = 0; RetReq = 0; RetiReq = 0;
    Zero = 0; Negative = 0; Carry = 0; IrqReq = 0; CounterValue = 0; pc = 0;
    m_flush = 0; m_inirq = 0; m_ovf = 0; m_unf = 0;

    tbl.push_back(mk(K_RST, 0, 0, 0, 16'h0000, 0, 4'b0000));
    for (int i = 1; i <= 5; i++) tbl.push_back(mk(K_IDLE, 0, 0, 0, 16'(i), 0, 4'b0000));
    tbl.push_back(mk(K_JMP,  16'h0020, 0, 0, 16'h0020, 0, 4'b0000));
    tbl.push_back(mk(K_IDLE, 0,        0, 0, 16'h0020, 1, 4'b0000));
    tbl.push_back(mk(K_BR,   16'h01FF, 1, 1, 16'h001F, 0, 4'b0000));
    tbl.push_back(mk(K_IDLE, 0,        0, 0, 16'h001F, 1, 4'b0000));
    tbl.push_back(mk(K_JMP,  16'h0020, 0, 0, 16'h0020, 0, 4'b0000));
    tbl.push_back(mk(K_IDLE, 0,        0, 0, 16'h0020, 1, 4'b0000));
    tbl.push_back(mk(K_BR,   16'h01FF, 1, 0, 16'h0021, 0, 4'b0000));
    tbl.push_back(mk(K_JMP,  16'h0100, 0, 0, 16'h0100, 0, 4'b0000));
    tbl.push_back(mk(K_IDLE, 0,        0, 0, 16'h0100, 1, 4'b0000));
    tbl.push_back(mk(K_CALL, 16'h0400, 0, 0, 16'h0400, 0, 4'b0000));
    tbl.push_back(mk(K_IDLE, 0,        0, 0, 16'h0400, 1, 4'b0000));
    tbl.push_back(mk(K_RET,  0,        0, 0, 16'h0101, 0, 4'b0000));
    tbl.push_back(mk(K_IDLE, 0,        0, 0, 16'h0101, 1, 4'b0000));
    tbl.push_back(mk(K_RET,  0,        0, 0, 16'h0102, 0, 4'b0001));
    for (int i = 0; i < 8; i++) begin
      tbl.push_back(mk(K_CALL, 16'h0200, 0, 0, 16'h0200, 0, 4'b0001));
      tbl.push_back(mk(K_IDLE, 0,        0, 0, 16'h0200, 1, 4'b0001));
    end
    tbl.push_back(mk(K_CALL, 16'h0200, 0, 0, 16'h0201, 0, 4'b0011));
    tbl.push_back(mk(K_RST,  0,        0, 0, 16'h0000, 0, 4'b0000));
    tbl.push_back(mk(K_JMP,  16'h0040, 0, 0, 16'h0040, 0, 4'b0000));
    tbl.push_back(mk(K_RST,  0,        0, 0, 16'h0000, 0, 4'b0000));
    tbl.push_back(mk(K_IDLE, 0,        0, 0, 16'h0001, 0, 4'b0000));
    tbl.push_back(mk(K_JMP,  16'h0055, 0, 0, 16'h0055, 0, 4'b0000));
    tbl.push_back(mk(K_IDLE, 0,        0, 0, 16'h0055, 1, 4'b0000));
    tbl.push_back(mk(K_IRQ,  0,        0, 0, 16'h0010, 0, 4'b1100));
    tbl.push_back(mk(K_IDLE, 0,        0, 0, 16'h0010, 1, 4'b0100));
    tbl.push_back(mk(K_IDLE, 0,        0, 0, 16'h0011, 0, 4'b0100));
    tbl.push_back(mk(K_IRQ,  0,        0, 0, 16'h0012, 0, 4'b0100));
    tbl.push_back(mk(K_RETI, 0,        0, 0, 16'h0055, 0, 4'b0000));
    tbl.push_back(mk(K_IDLE, 0,        0, 0, 16'h0055, 1, 4'b0000));
    tbl.push_back(mk(K_JCS,  16'h0300, 0, 0, 16'h0055, 0, 4'b0000));
    tbl.push_back(mk(K_JC,   16'h0300, 0, 0, 16'h0300, 0, 4'b0000));
    tbl.push_back(mk(K_IDLE, 0,        0, 0, 16'h0300, 1, 4'b0000));
    tbl.push_back(mk(K_RET,  0,        0, 0, 16'h0301, 0, 4'b0001));
    tbl.push_back(mk(K_JMP,  16'hFFFF, 0, 0, 16'hFFFF, 0, 4'b0001));
    tbl.push_back(mk(K_IDLE, 0,        0, 0, 16'hFFFF, 1, 4'b0001));
    tbl.push_back(mk(K_IDLE, 0,        0, 0, 16'h0000, 0, 4'b0001));
    tbl.push_back(mk(K_JMP,  16'h0002, 0, 0, 16'h0002, 0, 4'b0001));
    tbl.push_back(mk(K_IDLE, 0,        0, 0, 16'h0002, 1, 4'b0001));
    tbl.push_back(mk(K_BR,   16'h01FC, 0, 0, 16'hFFFE, 0, 4'b0001));
    tbl.push_back(mk(K_IDLE, 0,        0, 0, 16'hFFFE, 1, 4'b0001));
    tbl.push_back(mk(K_BR,   16'h0005, 7, 1, 16'hFFFF, 0, 4'b0001));

    @(posedge Clock);
    #1;
    foreach (tbl[i]) step(tbl[i], i);

    for (int i = 0; i < 3000; i++) begin
      v = '{default: 0};
      v.rst   = ($urandom_range(0, 199) == 0);
      v.stall = ($urandom_range(0, 9) == 0);
      v.jmp   = ($urandom_range(0, 19) == 0);
      v.call  = ($urandom_range(0, 5) == 0);
      v.ret   = ($urandom_range(0, 9) == 0);
      v.reti  = ($urandom_range(0, 11) == 0);
      v.br    = ($urandom_range(0, 3) == 0);
      v.irq   = ($urandom_range(0, 3) == 0);
      v.cond  = 3'($urandom_range(0, 7));
      v.off   = 9'($urandom);
      v.tgt   = 16'($urandom);
      v.z     = 1'($urandom_range(0, 1));
      v.n     = 1'($urandom_range(0, 1));
      v.c     = 1'($urandom_range(0, 1));
      step(v, 1000 + i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control-flow controller that drives the program counter's load and offset inputs. It turns decoded control-flow requests into per-cycle PC commands: stall, conditional relative branch, absolute jump, call/return via an internal return-address stack, and interrupt entry/exit. It sits between the instruction decode stage and the program counter and issues a one-cycle flush to fetch after every taken transfer.

## Interface
- RAS_DEPTH, 8, return-address stack entries (power of two, 2..16)
- IRQ_VECTOR, 16'h0010, absolute interrupt entry address
- Clock  in  1  system clock, all state updates on posedge
- Reset  in  1  synchronous, active-high; one clock, synchronous reset
- CounterValue  in  16  current PC value
- Stall  in  1  hold PC this cycle
- BranchReq  in  1  conditional relative branch request
- BranchCond  in  3  condition select
- BranchOffset  in  9  signed branch displacement
- JumpReq  in  1  absolute jump request
- JumpTarget  in  16  absolute target, used by jump and call
- CallReq  in  1  call to JumpTarget
- RetReq  in  1  return from call
- RetiReq  in  1  return from interrupt
- Zero, Negative, Carry  in  1 each  ALU flags
- IrqReq  in  1  level interrupt request
- LoadValue  out  16  to PC
- LoadEnable  out  1  to PC
- Offset  out  9  signed, to PC
- OffsetEnable  out  1  to PC
- Flush  out  1  discard fetched instruction
- IrqAck  out  1  one-cycle interrupt acceptance pulse
- InIrq  out  1  interrupt handler active
- StackOverflow, StackUnderflow  out  1 each  sticky error flags

## Operation
- PC contract: LoadEnable -> next = LoadValue; else OffsetEnable -> next = CounterValue + sign-extended Offset (mod 2^16); else next = CounterValue + 1.
- Command outputs are combinational from state and inputs; state, stack and flags are registered.
- States: RUN, FLUSH. Reset -> RUN.
- FLUSH: Flush=1, OffsetEnable=1, Offset=0 (PC holds), all requests ignored; FLUSH -> RUN next cycle.
- RUN with Stall=1: OffsetEnable=1, Offset=0; all requests and IrqReq ignored, not latched; stays RUN.
- RUN request priority: JumpReq > CallReq > RetReq > RetiReq > BranchReq > IrqReq > sequential.
- Jump: LoadValue=JumpTarget, LoadEnable=1 -> FLUSH.
- Call: push CounterValue+1, load JumpTarget -> FLUSH. Stack full: no push, no load, StackOverflow set, PC increments, stays RUN.
- Ret: pop, load popped value -> FLUSH. Stack empty: no load, StackUnderflow set, PC increments, stays RUN.
- Reti: as Ret, additionally clears InIrq. With InIrq=0 acts exactly as Ret.
- Branch conditions: 000 always, 001 Z, 010 !Z, 011 N, 100 !N, 101 C, 110 !C, 111 never. Taken: OffsetEnable=1, Offset=BranchOffset -> FLUSH. Not taken: sequential, no flush.
- Interrupt: accepted in RUN when IrqReq=1, InIrq=0, Stall=0, no other request, stack not full. Push CounterValue (interrupted instruction re-executes on Reti), load IRQ_VECTOR, IrqAck=1, InIrq set -> FLUSH. Blocked while InIrq=1 or stack full (stays pending, no flag).
- Sequential (nothing active): all command outputs 0.
- Error flags sticky until Reset.

## Timing
- Reset: LoadValue=0, LoadEnable=0, Offset=0, OffsetEnable=0, Flush=0, IrqAck=0, InIrq=0, flags=0, stack empty, state RUN. Reset mid-transfer discards FLUSH and stack contents.
- Request sampled in cycle N; PC shows new value after edge N; Flush=1 in cycle N+1; next request accepted in cycle N+2.
- Stack push/pop takes effect at edge N; Call and Ret never coincide (priority).
- Branch arithmetic wraps: 16'hFFFF + 1 -> 16'h0000; 16'h0002 + (-4) -> 16'hFFFE.
- Stall has zero latency and dominates everything except FLUSH (FLUSH also holds PC, so result identical).

## Test plan
- Reset, no requests 5 cycles -> all outputs 0, PC 0..5 sequential.
- CounterValue=16'h0020, BranchReq, cond 001, Zero=1, Offset=-1 -> OffsetEnable=1, Offset=-1, PC=16'h001F, Flush next cycle; Zero=0 -> no transfer, PC=16'h0021.
- Call at 16'h0100 to 16'h0400, then Ret -> LoadValue 16'h0400, then 16'h0101; 9 nested calls with RAS_DEPTH=8 -> 9th ignored, StackOverflow=1.
- Ret on empty stack -> no load, StackUnderflow=1, PC increments.
- IrqReq at 16'h0055 -> IrqAck pulse, PC=16'h0010, InIrq=1; second IrqReq blocked; Reti -> PC=16'h0055, InIrq=0.
- JumpReq and CallReq and Stall together -> PC held; Stall released -> jump wins, no push.
